// File: rtl/uart_pkg.sv
// Shared UART types and constants: transmitter state encoding, line levels,
// divisor width and the parity helper.
package uart_pkg;

    localparam int   UART_DIV_W       = 16;
    localparam int   UART_PAR_W       = 32;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_tx_state_t;

    // Zero-padding the payload does not change the XOR, so one width serves all.
    function automatic logic uart_parity(input logic [UART_PAR_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Read-side handshake between the TX FIFO and the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_rd_en;

    modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
    modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: reloads with the divisor on restart and at every period
// end, and flags the last cycle of each period with bit_tick_o.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [UART_DIV_W-1:0] div_i,
    output logic                  bit_tick_o
);
    logic [UART_DIV_W-1:0] cnt_q, cnt_d;

    // Down-count with reload
    always_comb begin
        cnt_d = cnt_q;
        if (load_i || (cnt_q == {UART_DIV_W{1'b0}})) begin
            cnt_d = div_i;
        end else begin
            cnt_d = cnt_q - {{(UART_DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {UART_DIV_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = (cnt_q == {UART_DIV_W{1'b0}});

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: drains the TX FIFO and sends 8N1/8N2 frames, LSB first.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int FWFT      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [UART_DIV_W-1:0] baud_div,
    input  logic                  parity_odd,
    uart_tx_if.master             fifo,
    output logic                  tx,
    output logic                  busy
);
    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    uart_tx_state_t        state_q, state_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [UART_DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  rd_en_s, load_s, bit_tick_s;
    logic [UART_PAR_W-1:0] data_pad_s;

    uart_baud_gen u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_s),
        .div_i      (div_d),
        .bit_tick_o (bit_tick_s)
    );

    // Zero-extend the FIFO word for the parity helper
    always_comb begin
        data_pad_s                  = {UART_PAR_W{1'b0}};
        data_pad_s[DATA_BITS-1:0]   = fifo.fifo_dout;
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        rd_en_s    = 1'b0;
        load_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = UART_IDLE_LEVEL;
                // rst_n gates the pop so a held reset never drains the FIFO
                if (rst_n && enable && !fifo.fifo_empty) begin
                    rd_en_s    = 1'b1;
                    busy_d     = 1'b1;
                    div_d      = baud_div;
                    bit_cnt_d  = {CNT_W{1'b0}};
                    stop_cnt_d = 1'b0;
                    if (FWFT != 0) begin
                        shift_d = fifo.fifo_dout;
                        par_d   = uart_parity(data_pad_s, parity_odd);
                        load_s  = 1'b1;
                        tx_d    = UART_START_LEVEL;
                        state_d = ST_START;
                    end else begin
                        par_d   = parity_odd;
                        state_d = ST_FETCH;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_FETCH: begin
                shift_d = fifo.fifo_dout;
                par_d   = uart_parity(data_pad_s, par_q);
                load_s  = 1'b1;
                tx_d    = UART_START_LEVEL;
                state_d = ST_START;
            end
            ST_START: begin
                if (bit_tick_s) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = ST_DATA;
                end else begin
                    tx_d = UART_START_LEVEL;
                end
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = {CNT_W{1'b0}};
`ifdef UART_TX_PARITY_EN
                        tx_d      = par_q;
                        state_d   = ST_PARITY;
`else
                        tx_d      = UART_IDLE_LEVEL;
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_PARITY: begin
                if (bit_tick_s) begin
                    tx_d    = UART_IDLE_LEVEL;
                    state_d = ST_STOP;
                end else begin
                    tx_d = par_q;
                end
            end
            ST_STOP: begin
                tx_d = UART_IDLE_LEVEL;
                if (bit_tick_s) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        stop_cnt_d = 1'b0;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end else begin
                    stop_cnt_d = stop_cnt_q;
                end
            end
            default: begin
                tx_d    = UART_IDLE_LEVEL;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= {DATA_BITS{1'b0}};
            div_q      <= {UART_DIV_W{1'b0}};
            bit_cnt_q  <= {CNT_W{1'b0}};
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= UART_IDLE_LEVEL;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx              = tx_q;
    assign busy            = busy_q;
    assign fifo.fifo_rd_en = rd_en_s;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one FWFT=1 and one FWFT=0 instance, each fed by
// a small queue-based FIFO model.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int FB     = 11;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int FB     = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n, en_a, en_b, parity_odd;
    logic [15:0] baud_div;
    logic        tx_a, busy_a, tx_b, busy_b;
    logic        sel_b;
    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];
    logic        pop_a = 1'b0;
    logic        pop_b = 1'b0;
    int          rd_cnt_a = 0;
    int          rd_cnt_b = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          at0, at1, at2;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_if #(.DATA_BITS(8)) ifa ();
    uart_tx_if #(.DATA_BITS(8)) ifb ();

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .FWFT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .baud_div(baud_div),
        .parity_odd(parity_odd), .fifo(ifa), .tx(tx_a), .busy(busy_a)
    );

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .FWFT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .baud_div(baud_div),
        .parity_odd(parity_odd), .fifo(ifb), .tx(tx_b), .busy(busy_b)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hand-written 10-bit frame {stop, data[7:0], start}, with the parity bit spliced in when enabled
    function automatic logic [10:0] mk(input logic [9:0] base, input logic pbit);
        return PAR_EN ? {base[9], pbit, base[8:0]} : {1'b0, base};
    endfunction

    task automatic wait_rd(input string tag, output int at);
        logic seen;
        seen = 1'b0;
        at   = -1;
        #1;
        for (int i = 0; i < 200; i++) begin
            if ((sel_b ? ifb.fifo_rd_en : ifa.fifo_rd_en) === 1'b1) begin
                seen = 1'b1;
                at   = cyc;
                break;
            end
            @(negedge clk); #1;
        end
        chk1({tag, "_rd_seen"}, seen, 1'b1);
    endtask

    task automatic check_frame(input string tag, input logic [10:0] f, input int per,
                               input int ncyc, input int drop_at);
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk); #1;
            chk1({tag, "_tx"}, sel_b ? tx_b : tx_a, f[n / per]);
            chk1({tag, "_busy"}, sel_b ? busy_b : busy_a, 1'b1);
            if (n == drop_at) en_a = 1'b0;
        end
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk); #1;
        chk1({tag, "_idle_tx"}, sel_b ? tx_b : tx_a, 1'b1);
        chk1({tag, "_idle_busy"}, sel_b ? busy_b : busy_a, 1'b0);
    endtask

    // FIFO model: pops land half a cycle after the rd_en edge
    initial begin
        ifa.fifo_empty = 1'b1;
        ifa.fifo_dout  = 8'h00;
        ifb.fifo_empty = 1'b1;
        ifb.fifo_dout  = 8'h5A;
        forever begin
            @(negedge clk);
            if (pop_a && q_a.size() > 0) void'(q_a.pop_front());
            pop_a = 1'b0;
            if (pop_b && q_b.size() > 0) ifb.fifo_dout = q_b.pop_front();
            pop_b = 1'b0;
            ifa.fifo_empty = (q_a.size() == 0);
            ifa.fifo_dout  = (q_a.size() != 0) ? q_a[0] : 8'h00;
            ifb.fifo_empty = (q_b.size() == 0);
            #2;
            if (ifa.fifo_rd_en === 1'b1) begin
                chk1("a_rd_while_empty", ifa.fifo_empty, 1'b0);
                pop_a = 1'b1;
                rd_cnt_a++;
            end
            if (ifb.fifo_rd_en === 1'b1) begin
                chk1("b_rd_while_empty", ifb.fifo_empty, 1'b0);
                pop_b = 1'b1;
                rd_cnt_b++;
            end
        end
    end

    initial begin
        rst_n = 1'b0; en_a = 1'b1; en_b = 1'b0; sel_b = 1'b0;
        baud_div = 16'd3; parity_odd = 1'b0;
        q_a.push_back(8'hA5);
        repeat (3) @(negedge clk);
        #1;
        chk1("rst_tx_a", tx_a, 1'b1);
        chk1("rst_busy_a", busy_a, 1'b0);
        chk1("rst_rd_a", ifa.fifo_rd_en, 1'b0);
        chk1("rst_tx_b", tx_b, 1'b1);
        chk1("rst_busy_b", busy_b, 1'b0);
        rst_n = 1'b1;

        // FWFT=1, div 3, 0xA5
        wait_rd("f1", at0);
        check_frame("f1", mk(10'b1_1010_0101_0, 1'b0), 4, 4 * FB, -1);
        idle_chk("f1");
        chkn("f1_rd_count", rd_cnt_a, 1);

        // FWFT=0, same byte; divisor change mid-frame must not take effect
        sel_b = 1'b1;
        q_b.push_back(8'hA5);
        en_b = 1'b1;
        wait_rd("f2", at0);
        @(negedge clk); #1;
        chk1("f2_fetch_tx", tx_b, 1'b1);
        chk1("f2_fetch_busy", busy_b, 1'b1);
        baud_div = 16'd0;
        check_frame("f2", mk(10'b1_1010_0101_0, 1'b0), 4, 4 * FB, -1);
        idle_chk("f2");
        en_b = 1'b0;
        chkn("f2_rd_count", rd_cnt_b, 1);
        sel_b = 1'b0;

        // Back-to-back frames at one cycle per bit
        en_a = 1'b0;
        baud_div = 16'd0;
        q_a.push_back(8'h00); q_a.push_back(8'hFF); q_a.push_back(8'h55);
        repeat (2) @(negedge clk);
        #1;
        en_a = 1'b1;
        wait_rd("f3a", at0);
        chk1("f3a_gap_busy", busy_a, 1'b0);
        check_frame("f3a", mk(10'b1_0000_0000_0, 1'b0), 1, FB, -1);
        wait_rd("f3b", at1);
        chkn("f3b_spacing", at1 - at0, FB + 1);
        chk1("f3b_gap_busy", busy_a, 1'b0);
        chk1("f3b_gap_tx", tx_a, 1'b1);
        check_frame("f3b", mk(10'b1_1111_1111_0, 1'b0), 1, FB, -1);
        wait_rd("f3c", at2);
        chkn("f3c_spacing", at2 - at1, FB + 1);
        check_frame("f3c", mk(10'b1_0101_0101_0, 1'b0), 1, FB, -1);
        idle_chk("f3");
        chkn("f3_rd_count", rd_cnt_a, 4);

        // Enable dropped during data bits of 0x3C
        en_a = 1'b0;
        baud_div = 16'd1;
        q_a.push_back(8'h3C); q_a.push_back(8'h7E);
        repeat (2) @(negedge clk);
        #1;
        en_a = 1'b1;
        wait_rd("f4a", at0);
        check_frame("f4a", mk(10'b1_0011_1100_0, 1'b0), 2, 2 * FB, 6);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk1("f4_hold_rd", ifa.fifo_rd_en, 1'b0);
        end
        chk1("f4_hold_tx", tx_a, 1'b1);
        chk1("f4_hold_busy", busy_a, 1'b0);
        chkn("f4_hold_rd_count", rd_cnt_a, 5);
        en_a = 1'b1;
        wait_rd("f4b", at0);
        check_frame("f4b", mk(10'b1_0111_1110_0, 1'b0), 2, 2 * FB, -1);
        idle_chk("f4");
        chkn("f4_rd_count", rd_cnt_a, 6);

        // Reset in data bit 4 of 0x96, then 0xC3 must go out intact
        en_a = 1'b0;
        baud_div = 16'd3;
        q_a.push_back(8'h96); q_a.push_back(8'hC3);
        repeat (2) @(negedge clk);
        #1;
        en_a = 1'b1;
        wait_rd("f5a", at0);
        check_frame("f5a", mk(10'b1_1001_0110_0, 1'b0), 4, 22, -1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk1("f5_rst_tx", tx_a, 1'b1);
        chk1("f5_rst_busy", busy_a, 1'b0);
        chk1("f5_rst_rd", ifa.fifo_rd_en, 1'b0);
        rst_n = 1'b1;
        wait_rd("f5b", at0);
        check_frame("f5b", mk(10'b1_1100_0011_0, 1'b0), 4, 4 * FB, -1);
        idle_chk("f5");
        chkn("f5_rd_count", rd_cnt_a, 8);

`ifdef UART_TX_PARITY_EN
        // Parity bit for 0xA5: even gives 0, odd gives 1
        en_a = 1'b0;
        parity_odd = 1'b0;
        q_a.push_back(8'hA5);
        repeat (2) @(negedge clk);
        #1;
        en_a = 1'b1;
        wait_rd("p0", at0);
        check_frame("p0", mk(10'b1_1010_0101_0, 1'b0), 4, 4 * FB, -1);
        idle_chk("p0");
        en_a = 1'b0;
        parity_odd = 1'b1;
        q_a.push_back(8'hA5);
        repeat (2) @(negedge clk);
        #1;
        en_a = 1'b1;
        wait_rd("p1", at0);
        check_frame("p1", mk(10'b1_1010_0101_0, 1'b1), 4, 4 * FB, -1);
        idle_chk("p1");
        chkn("p_rd_count", rd_cnt_a, 10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
